// File: rtl/grn_ctrl_pkg.sv
// Shared types and default widths for the GRN attractor sequencer.
package grn_ctrl_pkg;

    localparam int DEF_N_NODES = 8;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        STEP  = 3'd2,
        CHECK = 3'd3,
        EMIT  = 3'd4
    } state_t;

endpackage

// File: rtl/grn_init_iter.sv
// Walks the initial-state range: holds the current state and the captured
// last state, increments modulo 2^N_NODES and flags the final entry.
module grn_init_iter
    import grn_ctrl_pkg::*;
#(
    parameter int N_NODES = DEF_N_NODES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [N_NODES-1:0] init_first,
    input  logic [N_NODES-1:0] init_last,
    input  logic               advance,
    output logic [N_NODES-1:0] cur,
    output logic               is_last
);

    logic [N_NODES-1:0] last_q;

    // Capture the range on load; otherwise step cur, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur    <= '0;
            last_q <= '0;
        end else if (load) begin
            cur    <= init_first;
            last_q <= init_last;
        end else if (advance) begin
            cur    <= cur + 1'b1;
        end
    end

    // Equality is the only stop condition, so a descending range wraps through zero.
    assign is_last = (cur == last_q);

endmodule

// File: rtl/grn_attractor_ctrl.sv
// Sweeps initial network states, steps tortoise/hare node copies until they
// coincide or the step limit expires, and reports each outcome on a
// valid/ready result port.
module grn_attractor_ctrl
    import grn_ctrl_pkg::*;
#(
    parameter int N_NODES   = DEF_N_NODES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_STEPS = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_first,
    input  logic [N_NODES-1:0] init_last,
    output logic [N_NODES-1:0] reset_nos,
    output logic [N_NODES-1:0] start_s0,
    output logic [N_NODES-1:0] start_s1,
    output logic [N_NODES-1:0] init_state,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_steps,
    output logic               res_timeout,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX_STEPS);

    state_t             state;
    logic [CNT_W-1:0]   steps;
    logic [N_NODES-1:0] cur;
    logic               is_last;
    logic               load_range;
    logic               advance;

    assign load_range = (state == IDLE) && start;
    assign advance    = (state == EMIT) && res_ready && !is_last;

    grn_init_iter #(.N_NODES(N_NODES)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .load       (load_range),
        .init_first (init_first),
        .init_last  (init_last),
        .advance    (advance),
        .cur        (cur),
        .is_last    (is_last)
    );

    // The load strobe is registered, and cur already holds the state being
    // loaded during LOAD, so gating cur with it gives a one-cycle init_state.
    assign init_state = reset_nos[0] ? cur : '0;

    // Sequencer FSM; every strobe and result field is registered on the
    // transition into the state that presents it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            steps       <= '0;
            reset_nos   <= '0;
            start_s0    <= '0;
            start_s1    <= '0;
            res_valid   <= 1'b0;
            res_init    <= '0;
            res_steps   <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            reset_nos <= '0;
            start_s0  <= '0;
            start_s1  <= '0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        reset_nos <= '1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    steps    <= '0;
                    state    <= STEP;
                    start_s0 <= '1;
                    start_s1 <= '1;
                end
                STEP: begin
                    steps <= steps + 1'b1;
                    state <= CHECK;
                end
                CHECK: begin
                    // A match wins over the limit when both hold in one cycle.
                    if (s0_vec == s1_vec) begin
                        res_valid   <= 1'b1;
                        res_init    <= cur;
                        res_steps   <= steps;
                        res_timeout <= 1'b0;
                        state       <= EMIT;
                    end else if (steps == MAX_Q) begin
                        res_valid   <= 1'b1;
                        res_init    <= cur;
                        res_steps   <= steps;
                        res_timeout <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        state    <= STEP;
                        start_s0 <= '1;
                        start_s1 <= '1;
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (is_last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            reset_nos <= '1;
                            state     <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Randomized scoreboard bench for grn_attractor_ctrl with a behavioural
// node bank (identity, 3-state ring, free-running counter).
module tb_grn_attractor_ctrl;

    localparam int N    = 8;
    localparam int CW   = 16;
    localparam int MAXS = 10;

    typedef struct {
        logic [N-1:0]  init;
        logic [CW-1:0] steps;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  init_first = '0;
    logic [N-1:0]  init_last = '0;
    logic [N-1:0]  reset_nos, start_s0, start_s1, init_state, res_init;
    logic [N-1:0]  s0_vec = '0;
    logic [N-1:0]  s1_vec = '0;
    logic          res_valid, res_timeout, busy, done;
    logic          res_ready = 1'b0;
    logic [CW-1:0] res_steps;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   exp_done = 0;
    int   node_mode = 0;
    int   ready_mode = 2;
    logic ph = 1'b0;

    always #5 clk = ~clk;

    grn_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .init_first(init_first), .init_last(init_last),
        .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
        .init_state(init_state), .s0_vec(s0_vec), .s1_vec(s1_vec),
        .res_valid(res_valid), .res_ready(res_ready), .res_init(res_init),
        .res_steps(res_steps), .res_timeout(res_timeout),
        .busy(busy), .done(done)
    );

    // Network next-state map: 0 identity, 1 ring 001->010->100 in the low bits, 2 counter.
    function automatic logic [N-1:0] fmap(int mode, logic [N-1:0] x);
        case (mode)
            1:       fmap = {x[7:3], x[1:0], x[2]};
            2:       fmap = x + 8'd1;
            default: fmap = x;
        endcase
    endfunction

    function automatic logic [N-1:0] fpow(int mode, logic [N-1:0] x, int n);
        logic [N-1:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = fmap(mode, y);
        return y;
    endfunction

    // After k pulses the hare has made k moves and the tortoise k/2.
    function automatic exp_t ref_model(int mode, logic [N-1:0] x);
        exp_t e;
        e.init  = x;
        e.steps = CW'(MAXS);
        e.to    = 1'b1;
        for (int k = 1; k <= MAXS; k++) begin
            if (fpow(mode, x, k) == fpow(mode, x, k / 2)) begin
                e.steps = CW'(k);
                e.to    = 1'b0;
                return e;
            end
        end
        return e;
    endfunction

    // Behavioural node bank: loads on reset_nos, hare every pulse, tortoise every second pulse.
    always @(posedge clk) begin
        if (reset_nos[0]) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            ph     <= 1'b0;
        end else begin
            if (start_s1[0]) s1_vec <= fmap(node_mode, s1_vec);
            if (start_s0[0]) begin
                ph <= ~ph;
                if (ph) s0_vec <= fmap(node_mode, s0_vec);
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       res_ready = 1'($urandom_range(0, 1));
            1:       res_ready = 1'b0;
            default: res_ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on each handshake and checks hold/stall rules.
    initial begin
        logic          pv, phs, pto;
        logic [N-1:0]  pinit;
        logic [CW-1:0] psteps;
        exp_t          e;
        pv = 1'b0; phs = 1'b0; pto = 1'b0; pinit = '0; psteps = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                continue;
            end
            if (res_valid)
                chk("no_strobe_in_emit", 64'(reset_nos | start_s0 | start_s1), 64'd0);
            if (pv && !phs) begin
                chk("hold_valid", 64'(res_valid), 64'd1);
                chk("hold_fields", 64'({res_init, res_steps, res_timeout}),
                    64'({pinit, psteps, pto}));
            end
            if (res_valid && res_ready) begin
                chk("result_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("res_init", 64'(res_init), 64'(e.init));
                    chk("res_steps", 64'(res_steps), 64'(e.steps));
                    chk("res_timeout", 64'(res_timeout), 64'(e.to));
                end
            end
            if (done) begin
                chk("done_expected", 64'(exp_done > 0), 64'd1);
                chk("done_after_results", 64'(sb.size()), 64'd0);
                chk("busy_low_at_done", 64'(busy), 64'd0);
                if (exp_done > 0) exp_done--;
            end
            pv = res_valid; phs = res_valid && res_ready;
            pinit = res_init; psteps = res_steps; pto = res_timeout;
        end
    end

    // Queue expectations for the whole range, then pulse start for one cycle.
    task automatic run_sweep(int mode, logic [N-1:0] f, logic [N-1:0] l);
        logic [N-1:0] c;
        node_mode = mode;
        c = f;
        forever begin
            sb.push_back(ref_model(mode, c));
            if (c == l) break;
            c = c + 8'd1;
        end
        exp_done++;
        init_first = f;
        init_last  = l;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain(string name, int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || exp_done != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(sb.size() != 0 || exp_done != 0), 64'd0);
    endtask

    initial begin
        int rn, st, rv, n;
        logic [N-1:0] f;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({reset_nos, start_s0, start_s1, init_state, res_init,
                                  res_steps, res_valid, res_timeout, busy, done}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single state, identity network: timeline of the first evaluation.
        ready_mode = 2;
        node_mode  = 0;
        sb.push_back(ref_model(0, 8'h05));
        exp_done++;
        init_first = 8'h05;
        init_last  = 8'h05;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rn = -1; st = -1; rv = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (reset_nos != '0 && rn < 0) rn = c;
            if (start_s0 != '0 && st < 0) st = c;
            if (res_valid && rv < 0) rv = c;
        end
        chk("load_cycle", 64'(rn), 64'd1);
        chk("first_step_cycle", 64'(st), 64'd2);
        chk("valid_cycle", 64'(rv), 64'd4);
        wait_drain("drain_identity", 200);

        // Ring network and counter network (timeout path).
        ready_mode = 0;
        run_sweep(1, 8'h01, 8'h01);
        wait_drain("drain_ring", 500);
        run_sweep(2, 8'h00, 8'h00);
        wait_drain("drain_counter", 500);

        // Wrapping range FE..01.
        run_sweep(0, 8'hFE, 8'h01);
        wait_drain("drain_wrap", 1000);

        // Stall in EMIT for 20 cycles; start pulsed while busy must be ignored.
        ready_mode = 1;
        run_sweep(0, 8'h05, 8'h05);
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_valid_seen", 64'(res_valid), 64'd1);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                init_first = 8'h33;
                init_last  = 8'h40;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("stall_res_init", 64'(res_init), 64'h05);
        ready_mode = 0;
        wait_drain("drain_stall", 500);
        repeat (5) @(posedge clk);
        #1;
        chk("ignored_start_idle", 64'(busy), 64'd0);

        // Reset while in STEP, then restart from a fresh range.
        ready_mode = 2;
        run_sweep(2, 8'h10, 8'h12);
        n = 0;
        while (start_s0 == '0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_reached_step", 64'(start_s0 != '0), 64'd1);
        rst = 1'b1;
        sb.delete();
        exp_done = 0;
        @(posedge clk);
        #1;
        chk("midrst_outputs", 64'({reset_nos, start_s0, start_s1, init_state, res_init,
                                   res_steps, res_valid, res_timeout, busy, done}), 64'd0);
        rst = 1'b0;
        run_sweep(0, 8'h40, 8'h40);
        wait_drain("drain_restart", 200);

        // Randomized sweeps over all network modes with random backpressure.
        ready_mode = 0;
        for (int i = 0; i < 10; i++) begin
            f = 8'($urandom);
            run_sweep(int'($urandom_range(0, 2)), f, f + 8'($urandom_range(0, 4)));
            wait_drain("drain_random", 2000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
